wb_regfile_scoreboard: RTL and testbench
========================================

Name: wb_regfile_scoreboard

Overview:
Write-back end of the destination-register path. It consumes the 5-bit destination address produced by the writeback-destination select (rd / rt / 31). It holds the architectural register file with two read ports and one write port. It also tracks a per-register pending bit, which it sets when an instruction issues with a destination and clears when write-back completes. It drives a stall to the issue stage on RAW and WAW hazards.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; NREGS = 2**ADDR_W (32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
iss_valid  input  1  issue stage presents an instruction this cycle
iss_dest  input  ADDR_W  destination register from the writeback-destination select
iss_dest_en  input  1  instruction writes a register (1) or not (0: store/branch)
iss_src1  input  ADDR_W  source register 1 address
iss_src2  input  ADDR_W  source register 2 address
rd_data1  output  DATA_W  value of iss_src1 (combinational)
rd_data2  output  DATA_W  value of iss_src2 (combinational)
stall  output  1  issue must hold; instruction not accepted this cycle
wb_en  input  1  write-back strobe
wb_addr  input  ADDR_W  write-back register address
wb_data  input  DATA_W  write-back data
pending  output  NREGS  scoreboard bit vector, bit i = register i awaiting write-back
err_wb  output  1  sticky: write-back seen to a non-pending nonzero register

Behaviour:
- Reset (rst_n=0, async): all registers 0, pending=0, err_wb=0. Reads return 0 and stall=0 while in reset. Reset mid-operation discards all in-flight pending state.
- Register 0: reads always 0; writes ignored; pending[0] never set; stall never caused by address 0.
- Reads: combinational from the array, with write-through. If wb_en=1, wb_addr==srcN and srcN!=0, then rd_dataN=wb_data in the same cycle.
- Effective pending: eff_pend[i] = pending[i] & ~(wb_en & wb_addr==i). A completing write-back clears the hazard in the same cycle.
- stall = iss_valid & ( eff_pend[iss_src1] | eff_pend[iss_src2] | (iss_dest_en & eff_pend[iss_dest]) ). Address 0 terms are forced 0. Purely combinational; zero-cycle latency.
- Issue accept: iss_valid & ~stall. At the next edge, pending[iss_dest] <= 1 if iss_dest_en=1 and iss_dest!=0.
- Write-back: at the edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data and pending[wb_addr] <= 0.
- Simultaneous set and clear of the same index in one cycle: set wins, so the register ends pending=1 and the data is written.
- wb_en=1 to a nonzero address whose pending=0 at that edge: data is still written and err_wb <= 1, sticky until reset.
- Writes to different addresses from issue and write-back in the same cycle are independent.
- The scoreboard has no count depth; each register has a single pending bit. WAW is prevented by stall, so a second writer cannot issue before the first write-back.

Test Plan:
- Reset: hold rst_n=0, then release. Required: rd_data1=rd_data2=0, pending=0, stall=0, err_wb=0.
- Basic write/read: issue dest=5, then wb_en addr=5 data=0xDEADBEEF. Next cycle src1=5 gives rd_data1=0xDEADBEEF and pending[5]=0.
- RAW stall: issue dest=31 (jal), then next cycle iss_valid src2=31. Required: stall=1 each cycle until wb addr=31 data=0x00400008. In the wb cycle, stall=0 and rd_data2=0x00400008 (bypass).
- Register 0: issue dest=0 and wb addr=0 data=0xFFFFFFFF. Required: pending[0]=0, rd_data of src 0 = 0, never stall, err_wb stays 0.
- Same-cycle clear+set: pending[8]=1, wb addr=8 data=0x11 and issue dest=8 in the same cycle. Required: stall=0, reg8=0x11, pending[8]=1 after the edge.
- Error/async reset: wb addr=12 with pending[12]=0 gives err_wb=1. Then pulse rst_n low between edges: err_wb, pending and reg12 read 0 immediately.

Source files
------------

// File: rtl/wb_regfile_scoreboard_if.sv
// Bus bundle between the issue/write-back side and the register file scoreboard.
// Issue handshake: an instruction transfers on a rising edge where iss_valid=1 and stall=0;
// stall is the inverse of ready and may depend combinationally on the issue and wb fields.
interface wb_regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NREGS = 2 ** ADDR_W;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_dest;
  logic              iss_dest_en;
  logic [ADDR_W-1:0] iss_src1;
  logic [ADDR_W-1:0] iss_src2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              stall;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [NREGS-1:0]  pending;
  logic              err_wb;

  modport master (
    output iss_valid, iss_dest, iss_dest_en, iss_src1, iss_src2,
    output wb_en, wb_addr, wb_data,
    input  rd_data1, rd_data2, stall, pending, err_wb
  );

  modport slave (
    input  iss_valid, iss_dest, iss_dest_en, iss_src1, iss_src2,
    input  wb_en, wb_addr, wb_data,
    output rd_data1, rd_data2, stall, pending, err_wb
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with write-through reads and a per-register pending
// scoreboard that stalls issue on RAW/WAW hazards until the matching write-back.
module wb_regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wb_regfile_scoreboard_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              err_q, err_d;

  logic              wb_we;
  logic [NREGS-1:0]  wb_clr;
  logic [NREGS-1:0]  eff_pend;
  logic              haz_src1, haz_src2, haz_dest;
  logic              stall_c;
  logic              accept;
  logic [NREGS-1:0]  iss_set;

  // Address 0 is hardwired: it never writes, never pends and never hazards.
  always_comb begin
    wb_we    = bus.wb_en && (bus.wb_addr != '0);
    wb_clr   = wb_we ? (ONE_HOT0 << bus.wb_addr) : '0;
    eff_pend = pending_q & ~wb_clr;

    haz_src1 = (bus.iss_src1 != '0) && eff_pend[bus.iss_src1];
    haz_src2 = (bus.iss_src2 != '0) && eff_pend[bus.iss_src2];
    haz_dest = bus.iss_dest_en && (bus.iss_dest != '0) && eff_pend[bus.iss_dest];
    stall_c  = bus.iss_valid && (haz_src1 || haz_src2 || haz_dest);

    accept   = bus.iss_valid && !stall_c;
    iss_set  = (accept && bus.iss_dest_en && (bus.iss_dest != '0))
             ? (ONE_HOT0 << bus.iss_dest) : '0;

    // Set after clear so a same-cycle issue to the completing register stays pending.
    pending_d = eff_pend | iss_set;
    err_d     = err_q || (wb_we && !pending_q[bus.wb_addr]);
  end

  always_comb begin
    bus.rd_data1 = '0;
    bus.rd_data2 = '0;
    if (bus.iss_src1 != '0)
      bus.rd_data1 = (wb_we && bus.wb_addr == bus.iss_src1) ? bus.wb_data : regs_q[bus.iss_src1];
    if (bus.iss_src2 != '0)
      bus.rd_data2 = (wb_we && bus.wb_addr == bus.iss_src2) ? bus.wb_data : regs_q[bus.iss_src2];
    bus.stall   = stall_c;
    bus.pending = pending_q;
    bus.err_wb  = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_wb_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wb_regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.iss_valid   = 1'b0;
    bus.iss_dest    = '0;
    bus.iss_dest_en = 1'b0;
    bus.iss_src1    = '0;
    bus.iss_src2    = '0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input logic [4:0] dest, input logic dest_en,
                       input logic [4:0] s1, input logic [4:0] s2);
    bus.iss_valid   = 1'b1;
    bus.iss_dest    = dest;
    bus.iss_dest_en = dest_en;
    bus.iss_src1    = s1;
    bus.iss_src2    = s2;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();

    // Reset state, read while held in reset
    repeat (2) @(negedge clk);
    bus.iss_src1 = 5'd5;
    bus.iss_src2 = 5'd31;
    #1;
    check("rst_rd1", bus.rd_data1, 0);
    check("rst_rd2", bus.rd_data2, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_err", bus.err_wb, 0);
    next_cycle();
    rst_n = 1'b1;

    // Basic write/read
    next_cycle();
    issue(5'd5, 1'b1, 5'd0, 5'd0);
    #1 check("basic_issue_stall", bus.stall, 0);
    next_cycle();
    check("basic_pend5", bus.pending, 32'h0000_0020);
    wb(5'd5, 32'hDEADBEEF);
    next_cycle();
    bus.iss_src1 = 5'd5;
    #1;
    check("basic_rd1", bus.rd_data1, 32'hDEADBEEF);
    check("basic_pend_clr", bus.pending, 0);
    check("basic_err", bus.err_wb, 0);

    // RAW stall on r31 until its write-back, then bypass
    next_cycle();
    issue(5'd31, 1'b1, 5'd0, 5'd0);
    #1 check("raw_jal_stall", bus.stall, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      issue(5'd0, 1'b0, 5'd0, 5'd31);
      #1 check($sformatf("raw_stall_%0d", i), bus.stall, 1);
    end
    next_cycle();
    issue(5'd0, 1'b0, 5'd0, 5'd31);
    wb(5'd31, 32'h00400008);
    #1;
    check("raw_wb_stall", bus.stall, 0);
    check("raw_bypass_rd2", bus.rd_data2, 32'h00400008);
    next_cycle();
    check("raw_pend", bus.pending, 0);
    check("raw_err", bus.err_wb, 0);

    // Register 0 is inert
    next_cycle();
    issue(5'd0, 1'b1, 5'd0, 5'd0);
    wb(5'd0, 32'hFFFFFFFF);
    #1;
    check("r0_stall", bus.stall, 0);
    check("r0_rd1_nobypass", bus.rd_data1, 0);
    next_cycle();
    #1;
    check("r0_pend", bus.pending, 0);
    check("r0_err", bus.err_wb, 0);
    check("r0_rd1", bus.rd_data1, 0);

    // Same-cycle clear and set of r8; set wins, data written
    next_cycle();
    issue(5'd8, 1'b1, 5'd0, 5'd0);
    next_cycle();
    check("sc_pend8", bus.pending, 32'h0000_0100);
    issue(5'd8, 1'b1, 5'd8, 5'd0);
    wb(5'd8, 32'h11);
    #1;
    check("sc_stall", bus.stall, 0);
    check("sc_bypass_rd1", bus.rd_data1, 32'h11);
    next_cycle();
    bus.iss_src1 = 5'd8;
    #1;
    check("sc_pend_after", bus.pending, 32'h0000_0100);
    check("sc_rd8", bus.rd_data1, 32'h11);
    check("sc_err", bus.err_wb, 0);

    // WAW stall on r8 with no write-back
    next_cycle();
    issue(5'd8, 1'b1, 5'd0, 5'd0);
    #1 check("waw_stall", bus.stall, 1);

    // Independent issue r3 and write-back r8
    next_cycle();
    issue(5'd3, 1'b1, 5'd0, 5'd0);
    wb(5'd8, 32'h22);
    #1 check("indep_stall", bus.stall, 0);
    next_cycle();
    check("indep_pend3", bus.pending, 32'h0000_0008);
    wb(5'd3, 32'h33);
    next_cycle();
    bus.iss_src1 = 5'd3;
    bus.iss_src2 = 5'd8;
    #1;
    check("indep_pend0", bus.pending, 0);
    check("indep_rd3", bus.rd_data1, 32'h33);
    check("indep_rd8", bus.rd_data2, 32'h22);
    check("indep_err", bus.err_wb, 0);

    // Unexpected write-back sets sticky error
    next_cycle();
    wb(5'd12, 32'h0000ABCD);
    #1 check("err_before_edge", bus.err_wb, 0);
    next_cycle();
    issue(5'd20, 1'b1, 5'd0, 5'd0);
    bus.iss_src1 = 5'd12;
    #1;
    check("err_set", bus.err_wb, 1);
    check("err_rd12", bus.rd_data1, 32'h0000ABCD);
    next_cycle();
    check("err_sticky", bus.err_wb, 1);
    check("err_pend20", bus.pending, 32'h0010_0000);

    // Async reset pulse between edges discards everything immediately
    issue(5'd0, 1'b0, 5'd12, 5'd20);
    #1 check("pre_rst_stall", bus.stall, 1);
    rst_n = 1'b0;
    #1;
    check("arst_err", bus.err_wb, 0);
    check("arst_pend", bus.pending, 0);
    check("arst_rd12", bus.rd_data1, 0);
    check("arst_stall", bus.stall, 0);
    #1 rst_n = 1'b1;
    next_cycle();
    bus.iss_src1 = 5'd12;
    #1;
    check("post_rst_err", bus.err_wb, 0);
    check("post_rst_rd12", bus.rd_data1, 0);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
